red_pitaya_na_averager: RTL and testbench
=========================================

Name: red_pitaya_na_averager

Overview:
- Parametrised multi-channel averaging engine for network-analyzer sweeps. It generalises the fixed two-quadrature NA accumulator to NCH channels with configurable width.
- Adds a sample-valid strobe for decimated streams, per-channel saturation with sticky overflow flags, abort, and a one-cycle done pulse.
- Sits behind the IQ/filter blocks. The bus register file drives its configuration and start inputs and reads back its results.

Parameters:
NCH, 2, number of input channels averaged in parallel
INBITS, 24, signed width of each channel sample
ACCBITS, 62, signed accumulator width per channel (must be > INBITS)
CNTBITS, 32, width of sleep/average counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
start_i  in  1  one-cycle pulse; latches config, clears sums, begins a series
abort_i  in  1  one-cycle pulse; terminates the series without a done pulse
sleep_i  in  CNTBITS  clock cycles to wait before accumulating (latched at start)
averages_i  in  CNTBITS  number of valid samples to accumulate (latched at start)
valid_i  in  1  dat_i sample strobe
dat_i  in  NCH*INBITS  packed signed samples; channel k at bits [k*INBITS +: INBITS]
busy_o  out  1  high in SLEEP or ACCUM
done_o  out  1  one-cycle pulse when a series completes
sum_o  out  NCH*ACCBITS  packed signed accumulators, held until the next start
count_o  out  CNTBITS  samples accumulated so far
overflow_o  out  NCH  sticky per-channel saturation flag; cleared on start

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state goes to IDLE; busy_o=0, done_o=0, sum_o=0, count_o=0, overflow_o=0, latched config=0.
  - Reset overrides every other input, including mid-series.
- States: IDLE, SLEEP, ACCUM, DONE.
- Priority per cycle: rst_i > abort_i > start_i > normal progression.
- start_i sampled high at edge t (any state, including busy):
  - sums, count and overflow are cleared; sleep_i and averages_i are latched.
  - if sleep_i=0 then state(t+1)=ACCUM, else state(t+1)=SLEEP with remaining=sleep_i.
  - Restarting while busy discards the running series with no done pulse.
- SLEEP:
  - remaining decrements every clock, regardless of valid_i.
  - when remaining==1, the next state is ACCUM. ACCUM is therefore first active S cycles after entering SLEEP.
  - valid_i is ignored in SLEEP.
- ACCUM:
  - each cycle with valid_i=1: for every channel, sum_k <= sat(sum_k + sign_extend(dat_k)); count_o increments.
  - cycles with valid_i=0 hold state.
  - when an accumulation makes count_o equal to the latched averages, the next state is DONE.
  - If the latched averages=0, ACCUM moves to DONE on its first cycle, regardless of valid_i, with sums 0.
- DONE:
  - lasts one cycle; done_o=1, busy_o=0; then IDLE.
  - done_o is registered, so it is high in the cycle after the final accumulating edge.
- Saturation:
  - if the true sum exceeds the signed ACCBITS range, sum_k clamps to +max or -min and overflow_o[k] is set.
  - overflow_o[k] stays set until the next start or reset; accumulation continues on the clamped value.
- abort_i:
  - from SLEEP/ACCUM, next state is IDLE, busy_o=0, no done pulse.
  - sum_o and count_o hold their partial values.
  - In IDLE or DONE it has no effect.
- Outputs are registered, with no combinational input-to-output paths.
- sum_o and count_o update in the cycle after the accumulating edge.
- busy_o is asserted from the cycle after start_i until DONE.

Test Plan:
- Reset mid-series: NCH=2, start with sleep=5, averages=10, assert rst_i in ACCUM -> next cycle busy_o=0, sum_o=0, count_o=0, overflow_o=0, no done_o.
- Basic series: sleep=3, averages=4, valid_i=1 continuously, ch0=+100, ch1=-7 -> busy_o rises 1 cycle after start; first accumulation 3 cycles after SLEEP entry; sums 400/-28; count_o=4; done_o single pulse 1 cycle after 4th accumulation.
- Strobed input: sleep=0, averages=3, valid_i high every 4th cycle, ch0 values 1,2,3 -> sum0=6; samples on invalid cycles ignored; done_o after 3rd valid sample.
- Saturation: INBITS=24, ACCBITS=26, ch0=+2^23-1 for 16 samples -> sum0 clamps at 2^25-1, overflow_o[0]=1, overflow_o[1]=0, done_o still pulses; the next start clears the flag.
- Abort and restart: abort at count_o=2 -> IDLE, sums hold partial values, no done_o; start while busy -> sums cleared and new config latched, with exactly one done_o at the end of the new series.
- Edge config: averages=0, sleep=0 -> done_o 2 cycles after start, sum_o=0; start and abort in the same cycle -> abort wins, state IDLE.

Source files
------------

// File: rtl/red_pitaya_na_averager.sv
// Multi-channel averaging engine for network-analyzer sweeps: waits a programmable
// settle time, then accumulates a fixed number of strobed samples per channel with saturation.
module red_pitaya_na_averager #(
  parameter int NCH     = 2,
  parameter int INBITS  = 24,
  parameter int ACCBITS = 62,
  parameter int CNTBITS = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [CNTBITS-1:0]       sleep_i,
  input  logic [CNTBITS-1:0]       averages_i,
  input  logic                     valid_i,
  input  logic [NCH*INBITS-1:0]    dat_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [NCH*ACCBITS-1:0]   sum_o,
  output logic [CNTBITS-1:0]       count_o,
  output logic [NCH-1:0]           overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLEEP = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNTBITS-1:0] CNT_ONE = {{(CNTBITS-1){1'b0}}, 1'b1};

  // Returns {overflow, clamped_sum}; the sum is computed one bit wider to detect wrap.
  function automatic logic [ACCBITS:0] sat_add(input logic [ACCBITS-1:0] acc,
                                               input logic [INBITS-1:0]  smp);
    logic [ACCBITS:0] wide;
    logic [ACCBITS:0] res;
    wide = {acc[ACCBITS-1], acc} + {{(ACCBITS+1-INBITS){smp[INBITS-1]}}, smp};
    if (wide[ACCBITS] != wide[ACCBITS-1]) begin
      res = wide[ACCBITS] ? {1'b1, 1'b1, {(ACCBITS-1){1'b0}}}
                          : {1'b1, 1'b0, {(ACCBITS-1){1'b1}}};
    end else begin
      res = {1'b0, wide[ACCBITS-1:0]};
    end
    return res;
  endfunction

  state_t               state_q, state_d;
  logic [CNTBITS-1:0]   remaining_q, remaining_d;
  logic [CNTBITS-1:0]   averages_q, averages_d;
  logic [CNTBITS-1:0]   count_q, count_d;
  logic [NCH-1:0]       overflow_q, overflow_d;
  logic [ACCBITS-1:0]   sum_q [NCH];
  logic [ACCBITS-1:0]   sum_d [NCH];
  logic [ACCBITS:0]     sat_res [NCH];
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  for (genvar gk = 0; gk < NCH; gk++) begin : g_ch
    assign sat_res[gk] = sat_add(sum_q[gk], dat_i[gk*INBITS +: INBITS]);
    assign sum_o[gk*ACCBITS +: ACCBITS] = sum_q[gk];
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    averages_d  = averages_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    sum_d       = sum_q;
    // Abort outranks start in every state, so a simultaneous start is dropped.
    if (abort_i) begin
      state_d = ST_IDLE;
    end else if (start_i) begin
      for (int k = 0; k < NCH; k++) begin
        sum_d[k] = '0;
      end
      count_d     = '0;
      overflow_d  = '0;
      averages_d  = averages_i;
      remaining_d = sleep_i;
      state_d     = (sleep_i == '0) ? ST_ACCUM : ST_SLEEP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SLEEP: begin
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q <= CNT_ONE) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_SLEEP;
          end
        end
        ST_ACCUM: begin
          if (averages_q == '0) begin
            state_d = ST_DONE;
          end else if (valid_i) begin
            for (int k = 0; k < NCH; k++) begin
              sum_d[k]      = sat_res[k][ACCBITS-1:0];
              overflow_d[k] = overflow_q[k] | sat_res[k][ACCBITS];
            end
            count_d = count_q + CNT_ONE;
            if (count_d == averages_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_SLEEP) || (state_d == ST_ACCUM);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      averages_q  <= '0;
      count_q     <= '0;
      overflow_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        sum_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      averages_q  <= averages_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sum_q       <= sum_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_red_pitaya_na_averager.sv
// Scoreboard bench for red_pitaya_na_averager: stimulus queues expected series results,
// a done_o monitor pops and compares; cycle-exact checks cover timing, abort and reset.
module tb_red_pitaya_na_averager;
  localparam int NCH = 2, INBITS = 24, ACCBITS = 26, CNTBITS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, valid = 1'b0;
  logic [CNTBITS-1:0] sleep_v = '0, avg_v = '0;
  logic [NCH*INBITS-1:0] dat = '0;
  logic busy, done;
  logic [NCH*ACCBITS-1:0] sum;
  logic [CNTBITS-1:0] count;
  logic [NCH-1:0] ovf;
  logic signed [ACCBITS-1:0] sum0, sum1;

  assign sum0 = sum[0 +: ACCBITS];
  assign sum1 = sum[ACCBITS +: ACCBITS];

  red_pitaya_na_averager #(.NCH(NCH), .INBITS(INBITS), .ACCBITS(ACCBITS), .CNTBITS(CNTBITS)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .sleep_i(sleep_v), .averages_i(avg_v), .valid_i(valid), .dat_i(dat),
    .busy_o(busy), .done_o(done), .sum_o(sum), .count_o(count), .overflow_o(ovf));

  always #5 clk = ~clk;

  typedef struct {
    longint s0;
    longint s1;
    longint cnt;
    longint ov;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int n_done = 0;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dat(input int c0, input int c1);
    logic [31:0] a, b;
    a = c0;
    b = c1;
    dat = {b[INBITS-1:0], a[INBITS-1:0]};
  endtask

  task automatic push(input longint s0, input longint s1, input longint cnt, input longint ov);
    exp_t e;
    e.s0 = s0; e.s1 = s1; e.cnt = cnt; e.ov = ov;
    exp_q.push_back(e);
  endtask

  // Issue a one-cycle start pulse; returns just after the start edge.
  task automatic do_start(input int s, input int a);
    sleep_v = s;
    avg_v = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_sum0", longint'(sum0), e.s0);
        check("sb_sum1", longint'(sum1), e.s1);
        check("sb_count", longint'(count), e.cnt);
        check("sb_ovf", longint'(ovf), e.ov);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", longint'(sum), 0);
    check("rst_count", count, 0);
    check("rst_ovf", ovf, 0);

    // Basic series: sleep 3, 4 averages, continuous valid
    valid = 1'b1;
    set_dat(100, -7);
    push(400, -28, 4, 0);
    do_start(3, 4);
    check("basic_busy_rise", busy, 1);
    tick(); tick(); tick();
    check("basic_no_accum_in_sleep", count, 0);
    tick();
    check("basic_first_accum", count, 1);
    tick(); tick(); tick();
    check("basic_done_cycle", done, 1);
    check("basic_busy_in_done", busy, 0);
    tick();
    check("basic_done_single", done, 0);
    check("basic_count_hold", count, 4);
    valid = 1'b0;

    // Strobed input: valid every 4th cycle, garbage on invalid cycles
    push(6, 30, 3, 0);
    do_start(0, 3);
    for (int i = 0; i < 3; i++) begin
      valid = 1'b0;
      set_dat(1000, 500);
      tick(); tick(); tick();
      valid = 1'b1;
      set_dat(i + 1, 10);
      tick();
    end
    valid = 1'b0;
    check("strobe_done_cycle", done, 1);
    tick();

    // Saturation: positive clamp on ch0, ch1 stays in range
    valid = 1'b1;
    set_dat(32'h007F_FFFF, -5);
    push(33554431, -80, 16, 1);
    do_start(1, 16);
    wait_done("sat", 40);
    valid = 1'b0;
    tick();
    check("sat_ovf_sticky", ovf, 1);
    check("sat_sum_hold", longint'(sum0), 33554431);

    // Abort at count 2: partial sums held, start clears overflow
    valid = 1'b1;
    set_dat(3, 4);
    do_start(0, 10);
    check("abort_start_clears_ovf", ovf, 0);
    tick(); tick();
    check("abort_count_before", count, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_count_hold", count, 2);
    check("abort_sum0_hold", longint'(sum0), 6);
    check("abort_sum1_hold", longint'(sum1), 8);
    tick(); tick();
    check("abort_no_done", done, 0);
    check("abort_count_frozen", count, 2);

    // Restart while busy: first series discarded, one done for the second
    set_dat(1, 1);
    do_start(2, 5);
    tick(); tick(); tick();
    check("restart_first_count", count, 1);
    set_dat(7, -1);
    push(14, -2, 2, 0);
    do_start(1, 2);
    check("restart_cleared", count, 0);
    check("restart_busy", busy, 1);
    wait_done("restart", 20);
    valid = 1'b0;
    tick();

    // averages=0, sleep=0: done two cycles after start with zero sums
    push(0, 0, 0, 0);
    do_start(0, 0);
    check("zero_avg_not_yet", done, 0);
    tick();
    check("zero_avg_done", done, 1);
    tick();

    // Start and abort together: abort wins
    valid = 1'b1;
    set_dat(9, 9);
    abort = 1'b1;
    do_start(0, 5);
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    tick(); tick();
    check("start_abort_idle", busy, 0);
    check("start_abort_count", count, 0);

    // Reset mid-series while accumulating
    set_dat(2, 3);
    do_start(5, 10);
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    check("rst_mid_count_before", count, 2);
    rst = 1'b1;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_sum", longint'(sum), 0);
    check("rst_mid_count", count, 0);
    check("rst_mid_ovf", ovf, 0);
    rst = 1'b0;
    valid = 1'b0;
    tick(); tick();
    check("rst_mid_stays_idle", busy, 0);

    check("done_pulses", n_done, 5);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
